// File: rtl/csa_stream_acc.sv
// Streaming packet accumulator: keeps the running total in carry-save form and
// resolves it with one carry-propagate add on the packet's last beat.
module csa_stream_acc #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_beats,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q;
  logic [7:0]       cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] sum_q;
  logic [7:0]       beats_q;
  logic             oovf_q;

  logic             accept;
  logic [ACC_W-1:0] data_ext, new_s, raw_c, new_c;
  logic [ACC_W:0]   resolved;

  assign accept   = in_valid & in_ready;
  assign data_ext = {{(ACC_W-WIDTH){1'b0}}, in_data};
  assign new_s    = s_q ^ c_q ^ data_ext;
  assign raw_c    = (s_q & c_q) | (s_q & data_ext) | (c_q & data_ext);
  assign new_c    = {raw_c[ACC_W-2:0], 1'b0};
  assign resolved = {1'b0, s_q} + {1'b0, c_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && in_last) state_d = RESOLVE;
      RESOLVE: state_d = DONE;
      DONE:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
  end

  // A carry bit shifted out of the top is real weight 2^ACC_W, lost from the
  // redundant pair; since all terms are unsigned it marks overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      beats_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        s_q   <= new_s;
        c_q   <= new_c;
        cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        ovf_q <= ovf_q | raw_c[ACC_W-1];
      end
      if (state_q == RESOLVE) begin
        sum_q   <= resolved[ACC_W-1:0];
        beats_q <= cnt_q;
        oovf_q  <= ovf_q | resolved[ACC_W];
      end
      if (state_q == DONE && out_ready) begin
        s_q   <= '0;
        c_q   <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign out_sum   = sum_q;
  assign out_beats = beats_q;
  assign out_ovf   = oovf_q;

endmodule

// File: tb/tb_csa_stream_acc.sv
// Directed bench for csa_stream_acc: latency, saturation/overflow, backpressure,
// asynchronous reset, and a long run of packets against a plain integer total.
module tb_csa_stream_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [7:0]  out_beats;
  logic        out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  csa_stream_acc #(.WIDTH(4), .ACC_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  // Called at a negedge; presents one beat and returns at the negedge after it is taken.
  task automatic beat(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at a negedge; completes one result handshake and checks the fields.
  task automatic get_result(input int exp_sum, input int exp_beats, input logic exp_ovf);
    out_ready = 1'b1;
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_sum", {20'd0, out_sum}, exp_sum);
    chk("out_beats", {24'd0, out_beats}, exp_beats);
    chk("out_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf});
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int total, len, bcnt;
    logic [3:0] d;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", {20'd0, out_sum}, 32'd0);
    chk("rst_out_beats", {24'd0, out_beats}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat: out_valid appears two edges after acceptance.
    beat(4'd7, 1'b1);
    chk("lat_resolve_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_resolve_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("lat_done_valid", {31'd0, out_valid}, 32'd1);
    get_result(7, 1, 1'b0);

    // Three back-to-back beats of 15.
    out_ready = 1'b1;
    beat(4'd15, 1'b0);
    beat(4'd15, 1'b0);
    beat(4'd15, 1'b1);
    get_result(45, 3, 1'b0);

    // 300 beats of 15: 4500 mod 4096 = 404, count saturates.
    for (int i = 0; i < 300; i++) beat(4'd15, i == 299);
    get_result(404, 255, 1'b1);

    // Backpressure with a pending beat held across RESOLVE and DONE.
    beat(4'd1, 1'b0);
    beat(4'd2, 1'b0);
    beat(4'd3, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'd9;
    in_last  = 1'b1;
    chk("bp_resolve_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {20'd0, out_sum}, 32'd6);
      chk("bp_beats", {24'd0, out_beats}, 32'd3);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_pending_taken", {31'd0, in_ready}, 32'd0);
    get_result(9, 1, 1'b0);

    // Asynchronous reset mid-packet.
    beat(4'd5, 1'b0);
    beat(4'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {20'd0, out_sum}, 32'd0);
    chk("mid_rst_beats", {24'd0, out_beats}, 32'd0);
    chk("mid_rst_ovf", {31'd0, out_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(4'd4, 1'b1);
    get_result(4, 1, 1'b0);

    // Long run of packets with random length, data and gaps.
    for (int p = 0; p < 2000; p++) begin
      len   = $urandom_range(20, 1);
      total = 0;
      bcnt  = 0;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(3, 0) == 0) @(negedge clk);
        d = 4'($urandom_range(15, 0));
        total += int'(d);
        bcnt++;
        beat(d, b == len - 1);
      end
      for (int g = $urandom_range(3, 0); g > 0; g--) @(negedge clk);
      get_result(total % 4096, (bcnt > 255) ? 255 : bcnt, total >= 4096);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
